// File: rtl/johnson_decoder_monitor_if.sv
// Bus bundle for johnson_decoder_monitor: code sample input plus decoded/monitor outputs.
// The direction output exists only when JDEC_REVERSE_EN is defined.
interface johnson_decoder_monitor_if #(
  parameter int WIDTH = 4
);
  localparam int N  = 2 * WIDTH;
  localparam int IW = (N > 2) ? $clog2(N) : 1;

  logic            sample_en;
  logic [WIDTH-1:0] code_in;
  logic [IW-1:0]   index;
  logic [N-1:0]    onehot;
  logic            valid;
  logic            locked;
  logic            step_err;
  logic            wrap;
  logic [7:0]      err_count;
`ifdef JDEC_REVERSE_EN
  logic            dir;

  modport master (
    output sample_en, code_in,
    input  index, onehot, valid, locked, step_err, wrap, err_count, dir
  );
  modport slave (
    input  sample_en, code_in,
    output index, onehot, valid, locked, step_err, wrap, err_count, dir
  );
`else
  modport master (
    output sample_en, code_in,
    input  index, onehot, valid, locked, step_err, wrap, err_count
  );
  modport slave (
    input  sample_en, code_in,
    output index, onehot, valid, locked, step_err, wrap, err_count
  );
`endif
endinterface

// File: rtl/johnson_decoder_monitor.sv
// Johnson code decoder and sequence monitor: decodes, checks legality/stepping, tracks lock.
// Define JDEC_REVERSE_EN to accept reverse stepping and expose the dir output.
module johnson_decoder_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_LEN   = 3,
  parameter int ALLOW_HOLD = 1
) (
  input logic                    CLK,
  input logic                    CLR,
  johnson_decoder_monitor_if.slave bus
);
  localparam int N  = 2 * WIDTH;
  localparam int IW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  function automatic logic [WIDTH-1:0] encode(input int k);
    logic [WIDTH-1:0] c;
    for (int i = 0; i < WIDTH; i++)
      c[i] = (k <= WIDTH) ? (i < k) : (i >= k - WIDTH);
    return c;
  endfunction

  logic [1:0]    state, state_d;
  logic [3:0]    good_cnt, good_d, good_inc;
  int            pop, dec;
  logic [IW-1:0] idx_dec, q_inc;
  logic          legal, is_next, hold_ok;
  logic          advance, in_dir, at_edge;
  logic          bad_step, wrap_d;

  // Decode via popcount; legality is confirmed by re-encoding the decoded index.
  always_comb begin
    pop     = $countones(bus.code_in);
    dec     = (bus.code_in[0] || bus.code_in == '0) ? pop : N - pop;
    idx_dec = IW'(dec);
    legal   = (bus.code_in == encode(dec));
    q_inc   = (bus.index == IW'(N - 1)) ? '0 : bus.index + IW'(1);
    is_next = legal && (idx_dec == q_inc);
    hold_ok = legal && (idx_dec == bus.index) && (ALLOW_HOLD != 0);
  end

`ifdef JDEC_REVERSE_EN
  logic [IW-1:0] q_dec;
  logic          is_prev;

  always_comb begin
    q_dec   = (bus.index == '0) ? IW'(N - 1) : bus.index - IW'(1);
    is_prev = legal && (idx_dec == q_dec);
    advance = is_next || is_prev;
    // Once locked, only a step continuing the established direction is good.
    in_dir  = bus.dir ? is_prev : is_next;
    at_edge = bus.dir ? (bus.index == '0) : (bus.index == IW'(N - 1));
  end
`else
  always_comb begin
    advance = is_next;
    in_dir  = is_next;
    at_edge = (bus.index == IW'(N - 1));
  end
`endif

  assign good_inc = good_cnt + 4'd1;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state;
    good_d   = good_cnt;
    bad_step = 1'b0;
    wrap_d   = 1'b0;
    case (state)
      ST_UNLOCKED: begin
        if (legal) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (!legal) begin
          state_d = ST_UNLOCKED;
        end else if (!hold_ok) begin
          if (advance) begin
            good_d = good_inc;
            if (good_inc >= 4'(LOCK_LEN)) state_d = ST_LOCKED;
          end else begin
            good_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (!hold_ok) begin
          if (in_dir) begin
            wrap_d = at_edge;
          end else begin
            bad_step = 1'b1;
            state_d  = ST_UNLOCKED;
          end
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state         <= ST_UNLOCKED;
      good_cnt      <= '0;
      bus.index     <= '0;
      bus.onehot    <= '0;
      bus.valid     <= 1'b0;
      bus.step_err  <= 1'b0;
      bus.wrap      <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.step_err <= 1'b0;
      bus.wrap     <= 1'b0;
      if (bus.sample_en) begin
        state        <= state_d;
        good_cnt     <= good_d;
        bus.valid    <= legal;
        bus.onehot   <= legal ? (N'(1) << idx_dec) : '0;
        bus.step_err <= bad_step;
        bus.wrap     <= wrap_d;
        if (legal) bus.index <= idx_dec;
        if (bad_step && bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
      end
    end
  end

`ifdef JDEC_REVERSE_EN
  // Direction is learned while acquiring; in LOCKED any reversal is already a bad step.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      bus.dir <= 1'b0;
    end else if (bus.sample_en && state == ST_ACQUIRE && legal && !hold_ok && advance) begin
      bus.dir <= is_prev;
    end
  end
`endif

  assign bus.locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// Self-checking bench for johnson_decoder_monitor: directed scenarios plus randomized stepping
// checked against a table-driven sequence model. Honours JDEC_REVERSE_EN when defined.
module tb_johnson_decoder_monitor;
  localparam int WIDTH      = 4;
  localparam int N          = 2 * WIDTH;
  localparam int LOCK_LEN   = 3;
  localparam int ALLOW_HOLD = 1;

  logic CLK = 1'b0;
  logic CLR;

  johnson_decoder_monitor_if #(.WIDTH(WIDTH)) bus ();

  johnson_decoder_monitor #(
    .WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ALLOW_HOLD(ALLOW_HOLD)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] codes [N];

  // Reference model: phase 0 = unlocked, 1 = acquiring, 2 = locked.
  int m_phase, m_good, m_index, m_err;
  bit m_valid, m_step_err, m_wrap, m_dir;

  logic [22:0] obs;
  assign obs = {bus.index, bus.onehot, bus.valid, bus.locked, bus.step_err, bus.wrap, bus.err_count};

  function automatic logic [22:0] pack(int idx, bit v, bit l, bit se, bit w, int ec);
    logic [7:0] oh;
    oh = v ? (8'(1) << idx) : 8'h00;
    return {3'(idx), oh, v, l, se, w, 8'(ec)};
  endfunction

  function automatic logic [22:0] model_obs();
    return pack(m_index, m_valid, m_phase == 2, m_step_err, m_wrap, m_err);
  endfunction

  // Legal codes generated by stepping a Johnson register: shift left, feed back inverted MSB.
  task automatic build_codes();
    logic [WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      codes[i] = c;
      c = {c[WIDTH-2:0], ~c[WIDTH-1]};
    end
  endtask

  task automatic model_step(input bit clr, input bit en, input logic [WIDTH-1:0] code);
    int k, d, q;
    bit nxt, hld, prv;
    if (clr) begin
      m_phase = 0; m_good = 0; m_index = 0; m_err = 0;
      m_valid = 0; m_step_err = 0; m_wrap = 0; m_dir = 0;
      return;
    end
    m_step_err = 0;
    m_wrap     = 0;
    if (!en) return;
    k = -1;
    for (int j = 0; j < N; j++) if (codes[j] == code) k = j;
    if (k < 0) begin
      m_valid = 0;
      if (m_phase == 2) begin
        m_step_err = 1;
        if (m_err < 255) m_err++;
      end
      m_phase = 0;
      return;
    end
    q   = m_index;
    d   = (k - q + N) % N;
    nxt = (d == 1);
    hld = (d == 0) && (ALLOW_HOLD != 0);
`ifdef JDEC_REVERSE_EN
    prv = (d == N - 1);
`else
    prv = 0;
`endif
    m_valid = 1;
    m_index = k;
    case (m_phase)
      0: begin m_phase = 1; m_good = 0; end
      1: if (!hld) begin
           if (nxt || prv) begin
             m_good++;
             m_dir = prv;
             if (m_good >= LOCK_LEN) m_phase = 2;
           end else begin
             m_good = 0;
           end
         end
      default: if (!hld) begin
           if (nxt && !m_dir) m_wrap = (q == N - 1);
           else if (prv && m_dir) m_wrap = (q == 0);
           else begin
             m_step_err = 1;
             if (m_err < 255) m_err++;
             m_phase = 0;
           end
         end
    endcase
  endtask

  task automatic apply(input bit clr, input bit en, input logic [WIDTH-1:0] code);
    CLR           = clr;
    bus.sample_en = en;
    bus.code_in   = code;
    @(posedge CLK);
    #1;
    model_step(clr, en, code);
  endtask

  task automatic test_reset();
    logic [22:0] exp;
    exp = pack(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, 4'b1111);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset%0d got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_lock_sequence();
    logic [22:0] exp;
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, codes[i]);
      exp = pack(i, 1, i == 3, 0, 0, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL lock_seq%0d got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [22:0] exp [7];
    logic [WIDTH-1:0] stim [7];
    bit en [7];
    for (int i = 0; i < 4; i++) begin
      stim[i] = codes[i + 4]; en[i] = 1; exp[i] = pack(i + 4, 1, 1, 0, 0, 0);
    end
    stim[4] = codes[0]; en[4] = 1; exp[4] = pack(0, 1, 1, 0, 1, 0);
    stim[5] = codes[0]; en[5] = 1; exp[5] = pack(0, 1, 1, 0, 0, 0);
    stim[6] = codes[5]; en[6] = 0; exp[6] = pack(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      apply(0, en[i], stim[i]);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL wrap%0d got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [22:0] exp [4];
    logic [WIDTH-1:0] stim [4];
    bit en [4];
    stim[0] = codes[1]; en[0] = 1; exp[0] = pack(1, 1, 1, 0, 0, 0);
    stim[1] = codes[2]; en[1] = 1; exp[1] = pack(2, 1, 1, 0, 0, 0);
    stim[2] = 4'b0101;  en[2] = 1; exp[2] = pack(2, 0, 0, 1, 0, 1);
    stim[3] = codes[3]; en[3] = 0; exp[3] = pack(2, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      apply(0, en[i], stim[i]);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL illegal%0d got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_skip_relock();
    logic [22:0] exp [9];
    int seq [9];
    for (int i = 0; i < 4; i++) begin seq[i] = i; exp[i] = pack(i, 1, i == 3, 0, 0, 1); end
    seq[4] = 6; exp[4] = pack(6, 1, 0, 1, 0, 2);
    seq[5] = 7; exp[5] = pack(7, 1, 0, 0, 0, 2);
    seq[6] = 0; exp[6] = pack(0, 1, 0, 0, 0, 2);
    seq[7] = 1; exp[7] = pack(1, 1, 0, 0, 0, 2);
    seq[8] = 2; exp[8] = pack(2, 1, 1, 0, 0, 2);
    for (int i = 0; i < 9; i++) begin
      apply(0, 1, codes[seq[i]]);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL skip_relock%0d got %h expected %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_clr_midstream();
    logic [22:0] exp;
    for (int r = 0; r < 3; r++) begin
      apply(0, 1, 4'b0101);
      checks++;
      if (bus.err_count !== 8'(3 + r) || bus.locked !== 1'b0) begin
        errors++;
        $display("FAIL clr_err%0d got err %0d locked %b expected err %0d locked 0",
                 r, bus.err_count, bus.locked, 3 + r);
      end
      for (int j = 0; j < 4; j++) apply(0, 1, codes[(m_index + 1) % N]);
    end
    exp = pack(6, 1, 1, 0, 0, 5);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL clr_pre got %h expected %h", obs, exp);
    end
    apply(1, 1, codes[7]);
    exp = pack(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL clr_reset got %h expected %h", obs, exp);
    end
    apply(0, 1, codes[2]);
    exp = pack(2, 1, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL clr_after got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_random();
    int r;
    logic [WIDTH-1:0] code, nxt;
    bit en, clr;
    logic [22:0] exp;
    for (int i = 0; i < 600; i++) begin
      r   = $urandom_range(0, 99);
      nxt = codes[(m_index + 1) % N];
      en  = 1; clr = 0; code = nxt;
      if (r < 55)      code = nxt;
      else if (r < 65) code = codes[m_index];
      else if (r < 72) code = codes[(m_index + N - 1) % N];
      else if (r < 80) code = codes[$urandom_range(0, N - 1)];
      else if (r < 88) code = WIDTH'($urandom);
      else if (r < 97) begin en = 0; code = WIDTH'($urandom); end
      else clr = 1;
      apply(clr, en, code);
      exp = model_obs();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random%0d code %b en %b clr %b got %h expected %h",
                 i, code, en, clr, obs, exp);
      end
`ifdef JDEC_REVERSE_EN
      checks++;
      if (bus.dir !== m_dir) begin
        errors++;
        $display("FAIL random_dir%0d got %b expected %b", i, bus.dir, m_dir);
      end
`endif
    end
  endtask

`ifdef JDEC_REVERSE_EN
  task automatic test_reverse();
    logic [22:0] exp;
    int seq [4] = '{3, 2, 1, 0};
    apply(1, 0, '0);
    foreach (seq[i]) apply(0, 1, codes[seq[i]]);
    exp = pack(0, 1, 1, 0, 0, 0);
    checks++;
    if (obs !== exp || bus.dir !== 1'b1) begin
      errors++;
      $display("FAIL reverse_lock got %h dir %b expected %h dir 1", obs, bus.dir, exp);
    end
    apply(0, 1, codes[7]);
    exp = pack(7, 1, 1, 0, 1, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reverse_wrap got %h expected %h", obs, exp);
    end
    apply(0, 1, codes[0]);
    exp = pack(0, 1, 0, 1, 0, 1);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reverse_turn got %h expected %h", obs, exp);
    end
  endtask
`endif

  initial begin
    CLR           = 1'b1;
    bus.sample_en = 1'b0;
    bus.code_in   = '0;
    build_codes();
    model_step(1, 0, '0);
    test_reset();
    test_lock_sequence();
    test_wrap();
    test_illegal();
    test_skip_relock();
    test_clr_midstream();
`ifdef JDEC_REVERSE_EN
    test_reverse();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
